// File: rtl/insn_encoder_if.sv
// Request/response bundle for insn_encoder.
//   slave  : the encoder side (takes requests, produces encoded words)
//   master : the requester/consumer side
// Signals:
//   pc_load/load_pc          - overwrite the PC register
//   in_valid/in_ready        - request handshake
//   in_fmt..in_imm           - instruction fields; in_imm is the target address for B/J
//   out_valid/out_ready      - FIFO head handshake
//   out_insn/out_pc/out_err  - FIFO head contents
//   err_cnt                  - saturating count of errored requests
interface insn_encoder_if;
  logic        pc_load;
  logic [63:0] load_pc;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [63:0] out_pc;
  logic        out_err;
  logic [7:0]  err_cnt;

  modport master (
    output pc_load, load_pc, in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_insn, out_pc, out_err, err_cnt
  );

  modport slave (
    input  pc_load, load_pc, in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_insn, out_pc, out_err, err_cnt
  );
endinterface

// File: rtl/insn_encoder.sv
// RV64I instruction encoder with PC tracking.
// Requests are accepted on in_valid & in_ready, stamped with the current PC, registered in
// stage 1 (which also forms the PC-relative offset), then packed/checked in stage 2 and
// written into a 4-entry output FIFO. Illegal requests become a flagged NOP.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - insn_encoder_if.slave request/response bundle
// Configuration macro: ENCODER_MEXT_EN - when defined, R-format M-extension encodings
// (funct7 = 0000001 on opcodes 0110011/0111011) are legal; otherwise they are errors.
module insn_encoder (
  input  logic          clk,
  input  logic          reset,
  insn_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ, FmtSh, FmtIllegal
  } fmt_e;

  localparam logic [31:0] Nop = 32'h0000_0013;

  // True when v is representable as a signed value of msb+1 bits.
  function automatic logic sext_fits(logic [63:0] v, int unsigned msb);
    logic [63:0] t;
    t = $signed(v) >>> msb;
    return (t == '0) || (t == '1);
  endfunction

  // PC and handshake
  logic [63:0] pc_q, pc_d, req_pc;
  logic        in_ready, accept;

  // Stage 1
  logic        s1_valid_q;
  fmt_e        s1_fmt_q;
  logic [6:0]  s1_opcode_q, s1_funct7_q;
  logic [2:0]  s1_funct3_q;
  logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [63:0] s1_imm_q, s1_off_q, s1_pc_q;

  // Stage 2 (combinational, feeds the FIFO write port)
  logic [31:0] packed_insn, s2_insn;
  logic        s2_err, mext_err;

  // Output FIFO
  logic [31:0] mem_insn_q [4];
  logic [63:0] mem_pc_q   [4];
  logic        mem_err_q  [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        push, pop, out_valid;

  // Entries sitting in stage 1 are guaranteed a FIFO slot, so they count against capacity.
  assign in_ready = !reset && ((count_q + {2'b00, s1_valid_q}) < 3'd4);
  assign accept   = bus.in_valid && in_ready;

  // A same-cycle pc_load overrides the PC used for this request.
  assign req_pc = bus.pc_load ? bus.load_pc : pc_q;

  always_comb begin
    pc_d = pc_q;
    if (accept)           pc_d = req_pc + 64'd4;
    else if (bus.pc_load) pc_d = bus.load_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      s1_valid_q <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_fmt_q    <= fmt_e'(bus.in_fmt);
      s1_opcode_q <= bus.in_opcode;
      s1_funct3_q <= bus.in_funct3;
      s1_funct7_q <= bus.in_funct7;
      s1_rd_q     <= bus.in_rd;
      s1_rs1_q    <= bus.in_rs1;
      s1_rs2_q    <= bus.in_rs2;
      s1_imm_q    <= bus.in_imm;
      s1_off_q    <= bus.in_imm - req_pc;
      s1_pc_q     <= req_pc;
    end
  end

`ifdef ENCODER_MEXT_EN
  assign mext_err = 1'b0;
`else
  assign mext_err = (s1_funct7_q == 7'b0000001) &&
                    ((s1_opcode_q == 7'b0110011) || (s1_opcode_q == 7'b0111011));
`endif

  always_comb begin
    packed_insn = Nop;
    s2_err      = 1'b0;
    case (s1_fmt_q)
      FmtR: begin
        packed_insn = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
        s2_err      = mext_err;
      end
      FmtI: begin
        packed_insn = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
        s2_err      = !sext_fits(s1_imm_q, 11);
      end
      FmtS: begin
        packed_insn = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_imm_q[4:0],
                       s1_opcode_q};
        s2_err      = !sext_fits(s1_imm_q, 11);
      end
      FmtB: begin
        packed_insn = {s1_off_q[12], s1_off_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                       s1_off_q[4:1], s1_off_q[11], s1_opcode_q};
        s2_err      = s1_off_q[0] || !sext_fits(s1_off_q, 12);
      end
      FmtU: begin
        packed_insn = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
        s2_err      = (s1_imm_q[11:0] != 12'd0) || !sext_fits(s1_imm_q, 31);
      end
      FmtJ: begin
        packed_insn = {s1_off_q[20], s1_off_q[10:1], s1_off_q[11], s1_off_q[19:12],
                       s1_rd_q, s1_opcode_q};
        s2_err      = s1_off_q[0] || !sext_fits(s1_off_q, 20);
      end
      FmtSh: begin
        packed_insn = {s1_funct7_q[6:1], s1_imm_q[5:0], s1_rs1_q, s1_funct3_q, s1_rd_q,
                       s1_opcode_q};
        s2_err      = (s1_imm_q[63:6] != 58'd0);
      end
      default: s2_err = 1'b1;
    endcase
    s2_insn = s2_err ? Nop : packed_insn;
  end

  assign out_valid = (count_q != 3'd0);
  assign push      = s1_valid_q;
  assign pop       = out_valid && bus.out_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    err_cnt_d = err_cnt_q;
    if (push && s2_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_insn_q[wr_ptr_q] <= s2_insn;
      mem_pc_q[wr_ptr_q]   <= s1_pc_q;
      mem_err_q[wr_ptr_q]  <= s2_err;
    end
  end

  // Head is read straight from storage flops; forced to zero when the FIFO is empty.
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_insn  = out_valid ? mem_insn_q[rd_ptr_q] : 32'd0;
  assign bus.out_pc    = out_valid ? mem_pc_q[rd_ptr_q] : 64'd0;
  assign bus.out_err   = out_valid ? mem_err_q[rd_ptr_q] : 1'b0;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_insn_encoder.sv
module tb_insn_encoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  insn_encoder_if ifc ();

  insn_encoder dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] insn;
    logic [63:0] pc;
    bit          err;
    int          avail;
  } exp_t;

  exp_t        q[$];
  req_t        cur;
  logic [63:0] pc_m;
  int          err_m, cyc;
  int          n_checks, n_errors;
  int          n_pop, n_acc_dut;
  bit          obs_valid, obs_ready, obs_err;
  logic [31:0] obs_insn;
  logic [63:0] obs_pc;
  logic [7:0]  obs_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference encoder: legality from signed ranges, fields placed per RV64I formats.
  function automatic void ref_enc(input req_t r, input logic [63:0] pc,
                                  output logic [31:0] w, output bit e);
    longint      imm, off;
    logic [63:0] i, o;
    imm = r.imm;
    off = imm - longint'(pc);
    i   = r.imm;
    o   = off;
    e   = 1'b0;
    w   = 32'h0;
    case (r.fmt)
      3'd0: begin
        w = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
`ifndef ENCODER_MEXT_EN
        e = (r.f7 == 7'd1) && (r.op == 7'h33 || r.op == 7'h3b);
`endif
      end
      3'd1: begin
        e = imm < -2048 || imm > 2047;
        w = {i[11:0], r.rs1, r.f3, r.rd, r.op};
      end
      3'd2: begin
        e = imm < -2048 || imm > 2047;
        w = {i[11:5], r.rs2, r.rs1, r.f3, i[4:0], r.op};
      end
      3'd3: begin
        e = (off % 2 != 0) || off < -4096 || off > 4094;
        w = {o[12], o[10:5], r.rs2, r.rs1, r.f3, o[4:1], o[11], r.op};
      end
      3'd4: begin
        e = ((imm % 4096) != 0) || imm < -64'sd2147483648 || imm > 64'sd2147483647;
        w = {i[31:12], r.rd, r.op};
      end
      3'd5: begin
        e = (off % 2 != 0) || off < -1048576 || off > 1048574;
        w = {o[20], o[10:1], o[11], o[19:12], r.rd, r.op};
      end
      3'd6: begin
        e = imm < 0 || imm > 63;
        w = {r.f7[6:1], i[5:0], r.rs1, r.f3, r.rd, r.op};
      end
      default: e = 1'b1;
    endcase
    if (e) w = 32'h0000_0013;
  endfunction

  task automatic drive(input bit v, input req_t r);
    cur           = r;
    ifc.in_valid  = v;
    ifc.in_fmt    = r.fmt;
    ifc.in_opcode = r.op;
    ifc.in_funct3 = r.f3;
    ifc.in_funct7 = r.f7;
    ifc.in_rd     = r.rd;
    ifc.in_rs1    = r.rs1;
    ifc.in_rs2    = r.rs2;
    ifc.in_imm    = r.imm;
  endtask

  function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [63:0] imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.f3 = f3; r.f7 = f7;
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  // One clock: check outputs at the falling edge, advance the model, step to the rising edge.
  task automatic cycle();
    exp_t        e;
    bit          exp_valid, exp_ready;
    logic [63:0] base;
    @(negedge clk);
    foreach (q[k]) if (q[k].avail == cyc && q[k].err && err_m < 255) err_m++;
    exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
    exp_ready = !reset && (q.size() < 4);
    obs_valid = ifc.out_valid;
    obs_ready = ifc.in_ready;
    obs_insn  = ifc.out_insn;
    obs_pc    = ifc.out_pc;
    obs_err   = ifc.out_err;
    obs_cnt   = ifc.err_cnt;
    if (ifc.in_valid && ifc.in_ready && !reset) n_acc_dut++;
    chk("in_ready", 64'(ifc.in_ready), 64'(exp_ready));
    chk("out_valid", 64'(ifc.out_valid), 64'(exp_valid));
    chk("out_insn", 64'(ifc.out_insn), exp_valid ? 64'(q[0].insn) : 64'd0);
    chk("out_pc", ifc.out_pc, exp_valid ? q[0].pc : 64'd0);
    chk("out_err", 64'(ifc.out_err), exp_valid ? 64'(q[0].err) : 64'd0);
    chk("err_cnt", 64'(ifc.err_cnt), 64'(err_m));
    if (reset) begin
      q.delete();
      pc_m  = '0;
      err_m = 0;
    end else begin
      if (exp_valid && ifc.out_ready) begin
        void'(q.pop_front());
        n_pop++;
      end
      if (ifc.in_valid && exp_ready) begin
        base = ifc.pc_load ? ifc.load_pc : pc_m;
        ref_enc(cur, base, e.insn, e.err);
        e.pc    = base;
        e.avail = cyc + 2;
        q.push_back(e);
        pc_m = base + 64'd4;
      end else if (ifc.pc_load) begin
        pc_m = ifc.load_pc;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle();
    req_t r;
    r = mk(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd0);
    drive(1'b0, r);
    ifc.pc_load = 1'b0;
  endtask

  task automatic wait_head(input string tag);
    int k;
    k = 0;
    idle();
    do begin
      cycle();
      k++;
    end while (!obs_valid && k < 20);
    chk({tag, "_timeout"}, 64'(obs_valid), 64'd1);
  endtask

  task automatic rand_req(input logic [63:0] base, output req_t r);
    longint lo, hi, v;
    int     pick;
    r.fmt = 3'($urandom_range(0, 7));
    r.op  = 7'($urandom);
    r.f3  = 3'($urandom);
    r.f7  = 7'($urandom);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    if (r.fmt == 3'd0 && $urandom_range(0, 3) == 0) begin
      r.f7 = 7'd1;
      r.op = ($urandom_range(0, 1) == 0) ? 7'h33 : 7'h3b;
    end
    case (r.fmt)
      3'd1, 3'd2: begin lo = -2048; hi = 2047; end
      3'd3:       begin lo = -4096; hi = 4094; end
      3'd4:       begin lo = -64'sd2147483648; hi = 64'sd2147479552; end
      3'd5:       begin lo = -1048576; hi = 1048574; end
      3'd6:       begin lo = 0; hi = 63; end
      default:    begin lo = -16; hi = 16; end
    endcase
    pick = $urandom_range(0, 9);
    case (pick)
      0: v = lo;
      1: v = hi;
      2: v = lo - 1;
      3: v = (r.fmt == 3'd4) ? hi + 4096 : hi + 1;
      4: v = {$urandom, $urandom};
      default: begin
        v = lo + longint'($urandom) % (hi - lo + 1);
        if (r.fmt == 3'd3 || r.fmt == 3'd5) v[0] = 1'b0;
        if (r.fmt == 3'd4) v[11:0] = 12'd0;
      end
    endcase
    r.imm = (r.fmt == 3'd3 || r.fmt == 3'd5) ? base + v : v;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    req_t        r;
    logic [63:0] base;
    int          pops0;
    n_checks = 0; n_errors = 0; n_pop = 0; n_acc_dut = 0;
    cyc = 0; pc_m = '0; err_m = 0;
    reset = 1'b1;
    ifc.out_ready = 1'b1;
    ifc.load_pc   = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    cycle();                      // reset held: in_ready=0, outputs 0
    chk("reset_in_ready", 64'(obs_ready), 64'd0);
    chk("reset_out_valid", 64'(obs_valid), 64'd0);
    reset = 1'b0;

    // add x10,x11,x12 at PC 0, visible exactly 2 cycles after acceptance
    drive(1'b1, mk(3'd0, 7'h33, 3'd0, 7'd0, 5'd10, 5'd11, 5'd12, 64'd0));
    cycle();
    idle();
    cycle();
    chk("add_early", 64'(obs_valid), 64'd0);
    cycle();
    chk("add_valid", 64'(obs_valid), 64'd1);
    chk("add_insn", 64'(obs_insn), 64'h00C5_8533);
    chk("add_pc", obs_pc, 64'd0);
    chk("add_err", 64'(obs_err), 64'd0);

    // pc_load together with beq x5,x0 -> 0x1010
    drive(1'b1, mk(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd5, 5'd0, 64'h1010));
    ifc.pc_load = 1'b1;
    ifc.load_pc = 64'h1000;
    cycle();
    wait_head("beq");
    chk("beq_insn", 64'(obs_insn), 64'h0002_8863);
    chk("beq_pc", obs_pc, 64'h1000);

    // addi with out-of-range immediate
    drive(1'b1, mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 64'd2048));
    cycle();
    wait_head("addi");
    chk("addi_insn", 64'(obs_insn), 64'h13);
    chk("addi_err", 64'(obs_err), 64'd1);
    chk("addi_pc", obs_pc, 64'h1004);
    chk("addi_errcnt", 64'(obs_cnt), 64'd1);
    drive(1'b1, mk(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd4, 5'd5, 64'd0));
    cycle();
    wait_head("next");
    chk("next_pc", obs_pc, 64'h1008);

    // backpressure: 6 back-to-back requests, only 4 fit
    idle();
    repeat (3) cycle();
    ifc.out_ready = 1'b0;
    n_acc_dut = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, mk(3'd0, 7'h33, 3'd0, 7'd0, 5'(k + 1), 5'd1, 5'd2, 64'd0));
      cycle();
    end
    chk("bp_accepted", 64'(n_acc_dut), 64'd4);
    chk("bp_in_ready", 64'(obs_ready), 64'd0);
    idle();
    ifc.out_ready = 1'b1;
    pops0 = n_pop;
    repeat (8) cycle();
    chk("bp_drained", 64'(n_pop - pops0), 64'd4);

    // mul x1,x2,x3
    drive(1'b1, mk(3'd0, 7'h33, 3'd0, 7'd1, 5'd1, 5'd2, 5'd3, 64'd0));
    cycle();
    wait_head("mul");
`ifdef ENCODER_MEXT_EN
    chk("mul_insn", 64'(obs_insn), 64'h0231_00B3);
    chk("mul_err", 64'(obs_err), 64'd0);
`else
    chk("mul_insn", 64'(obs_insn), 64'h13);
    chk("mul_err", 64'(obs_err), 64'd1);
`endif

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      ifc.pc_load   = ($urandom_range(0, 19) == 0);
      ifc.load_pc   = {$urandom, $urandom} & ~64'd3;
      base          = ifc.pc_load ? ifc.load_pc : pc_m;
      rand_req(base, r);
      drive($urandom_range(0, 9) < 7, r);
      cycle();
    end

    // reset with entries queued
    idle();
    ifc.out_ready = 1'b1;
    repeat (4) cycle();
    ifc.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, mk(3'd1, 7'h13, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 64'(k)));
      cycle();
    end
    idle();
    repeat (3) cycle();
    chk("rst_queued", 64'(obs_valid), 64'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    chk("rst_flush", 64'(obs_valid), 64'd0);
    ifc.out_ready = 1'b1;
    drive(1'b1, mk(3'd0, 7'h33, 3'd0, 7'd0, 5'd10, 5'd11, 5'd12, 64'd0));
    cycle();
    wait_head("post_rst");
    chk("post_rst_pc", obs_pc, 64'd0);
    chk("post_rst_insn", 64'(obs_insn), 64'h00C5_8533);
    idle();
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/insn_encoder.md
INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 SHALL have ports: clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have ports: reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports: pc_load, input, 1, loads the PC register from load_pc.
REQ-004 SHALL have ports: load_pc, input, 64, new PC value.
REQ-005 SHALL have ports: in_valid, input, 1, request valid.
REQ-006 SHALL have ports: in_ready, output, 1, encoder can accept a request.
REQ-007 SHALL have ports: in_fmt, input, 3, format select: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SH (shift-imm), 7=illegal.
REQ-008 SHALL have ports: in_opcode, input, 7, major opcode, copied to insn[6:0].
REQ-009 SHALL have ports: in_funct3, input, 3, funct3 field.
REQ-010 SHALL have ports: in_funct7, input, 7, funct7 field; bits [6:1] are funct6 for SH.
REQ-011 SHALL have ports: in_rd, in_rs1, in_rs2, input, 5 each, register numbers.
REQ-012 SHALL have ports: in_imm, input, 64, signed immediate; absolute target address for B and J.
REQ-013 SHALL have ports: out_valid, output, 1, head entry valid.
REQ-014 SHALL have ports: out_ready, input, 1, consumer takes the head entry.
REQ-015 SHALL have ports: out_insn, output, 32, encoded instruction.
REQ-016 SHALL have ports: out_pc, output, 64, PC of out_insn.
REQ-017 SHALL have ports: out_err, output, 1, encoding error flag for the head entry.
REQ-018 SHALL have ports: err_cnt, output, 8, saturating count of errored requests.

Function
REQ-019 SHALL accept a request on a cycle where in_valid and in_ready are both 1; SHALL ignore all inputs otherwise.
REQ-020 SHALL assign the current PC to each accepted request, then advance PC by 4.
REQ-021 SHALL give pc_load priority over the advance: a load and accept in the same cycle assigns load_pc to that request, and PC becomes load_pc+4.
REQ-022 SHALL use a two-stage pipeline: stage 1 registers the fields and computes off = in_imm - pc (64-bit); stage 2 packs the word and runs the checks.
REQ-023 SHALL write the stage-2 result into a 4-entry output FIFO; an entry accepted in cycle N is at the head no earlier than cycle N+2.
REQ-024 SHALL drive in_ready = (fifo_count + in-flight stage entries) < 4, so no accepted entry is ever dropped.
REQ-025 SHALL pack each format per RV64I: R, I, S, B (off[12|10:5], off[4:1|11]), U (imm[31:12]), J (off[20|10:1|11|19:12]), SH (funct6, shamt[5:0]).
REQ-026 SHALL flag an error when: I or S imm is outside [-2048,2047]; B off is odd or outside [-4096,4094]; J off is odd or outside [-1048576,1048574]; U imm[11:0] is not 0 or imm is outside the sign-extended 32-bit range; SH imm is outside [0,63]; or fmt is 7.
REQ-027 SHALL, on error, emit out_insn=32'h00000013 with out_err=1 and the request's PC; PC advance is unaffected.
REQ-028 SHALL increment err_cnt once per errored entry written into the FIFO, saturating at 255.
REQ-029 SHALL pop the head when out_valid and out_ready are both 1; a simultaneous push and pop leaves the count unchanged.
REQ-030 SHALL use wrap-around 2-bit FIFO pointers; out_valid = (count != 0).
REQ-031 SHALL drive out_insn, out_pc and out_err as registered FIFO-head values, holding them stable while out_valid=1 and out_ready=0.

Reset
REQ-032 SHALL, on reset, clear PC to 0, stage valids, FIFO pointers, count and err_cnt.
REQ-033 SHALL drive outputs to 0 from the cycle after reset: out_valid, out_insn, out_pc, out_err, err_cnt; in_ready=0 while reset=1.
REQ-034 SHALL discard in-flight and queued entries when reset is asserted mid-operation; no output is produced for them.

Configuration
REQ-035 SHALL, with ENCODER_MEXT_EN defined, encode R-format requests with funct7=7'b0000001 (opcodes 0110011 and 0111011) normally.
REQ-036 SHALL, without ENCODER_MEXT_EN, treat those requests as errors per REQ-027.

Verification
REQ-037 Reset, then R add (rd=10, rs1=11, rs2=12, opcode 0110011) -> out_insn=0x00C58533, out_pc=0, err=0, visible 2 cycles after accept.
REQ-038 pc_load=0x1000 with B beq (rs1=5, rs2=0, target 0x1010) -> out_insn=0x00028863, out_pc=0x1000.
REQ-039 I addi imm=2048 -> out_insn=0x00000013, out_err=1, err_cnt=1; the next request is at out_pc+4.
REQ-040 out_ready=0 with 6 back-to-back requests -> exactly 4 accepted, then in_ready=0; releasing out_ready gives in-order output and no loss.
REQ-041 mul x1,x2,x3 -> 0x023100B3 with ENCODER_MEXT_EN defined; out_err=1 without it.
REQ-042 Reset asserted with 3 entries queued -> out_valid=0 the next cycle; a subsequent request gets out_pc=0.
